// File: rtl/risc_pkg.sv
// Shared VeriRISC definitions: opcode encodings, controller phases and the
// ALU-operation membership test used by the controller's strobe decode.
package risc_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR,
    INST_FETCH,
    INST_LOAD,
    IDLE,
    OP_ADDR,
    OP_FETCH,
    ALU_OP,
    STORE
  } phase_t;

  // Opcodes whose operand is read from memory and written back through the ALU.
  function automatic logic is_aluop(input logic [2:0] op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction

endpackage

// File: rtl/risc_phase_cnt.sv
// Eight-phase instruction sequencer: advances one phase per clock, wrapping
// STORE back to INST_ADDR, and freezes while hold is asserted.
module risc_phase_cnt
  import risc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  output phase_t phase
);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= INST_ADDR;
    end else if (!hold) begin
      phase <= phase_t'(3'(phase + 3'd1));
    end
  end

endmodule

// File: rtl/risc_controller.sv
// VeriRISC instruction-sequencing controller: phase machine, halt state,
// retired-instruction counter and datapath strobe decode.
// Optional: define CTRL_STEP_EN to add a `step` input that resumes from HLT.
module risc_controller
  import risc_pkg::*;
#(
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        opcode,
  input  logic              zero,
`ifdef CTRL_STEP_EN
  input  logic              step,
`endif
  output logic              sel,
  output logic              rd,
  output logic              ld_ir,
  output logic              inc_pc,
  output logic              halt,
  output logic              ld_pc,
  output logic              data_e,
  output logic              ld_ac,
  output logic              wr,
  output logic [2:0]        phase,
  output logic [ICNT_W-1:0] instr_cnt
);

  phase_t phase_q;
  logic   halted;
  logic   halt_set;
  logic   resume;
  logic   aluop;

  // The phase stays put on the resume edge, so HLT completes from OP_FETCH.
  risc_phase_cnt u_phase_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (halted),
    .phase (phase_q)
  );

  assign phase    = phase_q;
  assign aluop    = is_aluop(opcode);
  assign halt_set = !halted && (phase_q == OP_ADDR) && (opcode == HLT);

`ifdef CTRL_STEP_EN
  assign resume = halted && step;
`else
  assign resume = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted <= 1'b0;
    end else if (resume) begin
      halted <= 1'b0;
    end else if (halt_set) begin
      halted <= 1'b1;
    end
  end

  // An instruction retires on the STORE -> INST_ADDR transition only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
    end else if (!halted && (phase_q == STORE)) begin
      instr_cnt <= instr_cnt + ICNT_W'(1);
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a strobe unassigned and infers a latch.
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
      endcase
    end
  end

endmodule
